// File: rtl/wb_pkg.sv
// Shared widths and the writeback entry carried from the LSU into the
// result buffer and on to the register-file write stage.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two result buffer for LSU writebacks; the pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;
  wb_entry_t   mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A push on a full buffer is legal only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback/hazard controller: merges ALU and buffered LSU results into one
// registered regfile write port, tracks in-flight long ops and stalls issue.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned LSU_FIFO_DEPTH = 2,
  parameter int unsigned MAX_PENDING    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue_valid,
  input  logic [4:0]                       issue_rd,
  input  logic [4:0]                       issue_rs1,
  input  logic [4:0]                       issue_rs2,
  input  logic                             issue_use_rs1,
  input  logic                             issue_use_rs2,
  input  logic                             issue_is_long,
  output logic                             issue_stall,
  input  logic                             alu_valid,
  output logic                             alu_ready,
  input  logic [4:0]                       alu_rd,
  input  logic [XLEN-1:0]                  alu_data,
  input  logic                             lsu_valid,
  output logic                             lsu_ready,
  input  logic [4:0]                       lsu_rd,
  input  logic [XLEN-1:0]                  lsu_data,
  output logic                             rf_we,
  output logic [4:0]                       rf_waddr,
  output logic [XLEN-1:0]                  rf_wdata,
  output logic                             fwd1_valid,
  output logic                             fwd2_valid,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
  output logic                             err_spurious
);

  localparam int unsigned PW = $clog2(MAX_PENDING + 1);

  logic [31:0]     busy_q, busy_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            fifo_full, fifo_empty, fifo_pop, lsu_push;
  wb_entry_t       fifo_head, lsu_entry;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            fire, fire_long, pend_dec;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign lsu_ready = ~fifo_full;
  assign lsu_push  = lsu_valid & ~fifo_full;

  wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lsu_push),
    .entry_i (lsu_entry),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    issue_stall = issue_valid & ((issue_use_rs1 & busy_q[issue_rs1]) |
                                 (issue_use_rs2 & busy_q[issue_rs2]) |
                                 busy_q[issue_rd] |
                                 (issue_is_long & (pending_q == PW'(MAX_PENDING))));
    fire      = issue_valid & ~issue_stall;
    fire_long = fire & issue_is_long;
  end

  // A full buffer always wins so the LSU can never be blocked indefinitely by ALU traffic.
  always_comb begin
    alu_ready = ~fifo_full;
    fifo_pop  = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (fifo_full) begin
      fifo_pop  = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = fifo_head.rd;
      sel_data  = fifo_head.data;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = fifo_head.rd;
      sel_data  = fifo_head.data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
    if (fire_long && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    // Saturate at zero so an unexpected LSU return cannot wrap the count.
    pend_dec  = fifo_pop & (pending_q != '0);
    pending_d = pending_q;
    if (fire_long && !pend_dec) pending_d = pending_q + PW'(1);
    else if (!fire_long && pend_dec) pending_d = pending_q - PW'(1);

    err_d = err_q | (lsu_push & ~busy_q[lsu_rd] & (lsu_rd != 5'd0));

    we_d    = sel_valid & (sel_rd != 5'd0);
    waddr_d = sel_valid ? sel_rd : waddr_q;
    wdata_d = sel_valid ? sel_data : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rf_we         = we_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
  assign pending_count = pending_q;
  assign err_spurious  = err_q;
  assign fwd1_valid    = we_q & (waddr_q == issue_rs1) & (issue_rs1 != 5'd0);
  assign fwd2_valid    = we_q & (waddr_q == issue_rs2) & (issue_rs2 != 5'd0);

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench: handshakes push expected writes into per-source queues,
// the negedge monitor pops and compares every regfile write.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_is_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd1_valid, fwd2_valid;
  logic [2:0]  pending_count;
  logic        err_spurious;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned alu_stalls = 0;
  logic [36:0] alu_q[$];
  logic [36:0] lsu_q[$];

  always #5 clk = ~clk;

  wb_scoreboard #(
    .XLEN           (32),
    .LSU_FIFO_DEPTH (2),
    .MAX_PENDING    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_is_long (issue_is_long),
    .issue_stall   (issue_stall),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .fwd1_valid    (fwd1_valid),
    .fwd2_valid    (fwd2_valid),
    .pending_count (pending_count),
    .err_spurious  (err_spurious)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (rst) begin
      alu_q.delete();
      lsu_q.delete();
    end else begin
      if (rf_we) begin
        if (alu_q.size() > 0 && alu_q[0][36:32] == rf_waddr) begin
          e = alu_q.pop_front();
          check("wr_addr", {27'b0, rf_waddr}, {27'b0, e[36:32]});
          check("wr_data", rf_wdata, e[31:0]);
        end else if (lsu_q.size() > 0) begin
          e = lsu_q.pop_front();
          check("wr_addr", {27'b0, rf_waddr}, {27'b0, e[36:32]});
          check("wr_data", rf_wdata, e[31:0]);
        end else begin
          check("unexpected_we", {31'b0, rf_we}, 32'd0);
        end
      end
      if (alu_valid && alu_ready && alu_rd != 5'd0) alu_q.push_back({alu_rd, alu_data});
      if (alu_valid && !alu_ready) alu_stalls++;
      if (lsu_valid && lsu_ready && lsu_rd != 5'd0) lsu_q.push_back({lsu_rd, lsu_data});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic u1, input logic [4:0] rs2, input logic u2,
                           input logic lng);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_use_rs1 = u1;
    issue_rs2 = rs2; issue_use_rs2 = u2; issue_is_long = lng;
  endtask

  task automatic alu_send(input logic [4:0] rd, input logic [31:0] data);
    int n = 0;
    alu_valid = 1'b1; alu_rd = rd; alu_data = data;
    do begin
      @(negedge clk);
      n++;
    end while (!alu_ready && n < 50);
    if (!alu_ready) check("alu_timeout", {31'b0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
  endtask

  task automatic lsu_send(input logic [4:0] rd, input logic [31:0] data);
    int n = 0;
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = data;
    do begin
      @(negedge clk);
      n++;
    end while (!lsu_ready && n < 50);
    if (!lsu_ready) check("lsu_timeout", {31'b0, lsu_ready}, 32'd1);
    step();
    lsu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_issue(0, 0, 0, 0, 0, 0, 0);
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    step(2);
    check("rst_we", {31'b0, rf_we}, 32'd0);
    check("rst_waddr", {27'b0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_pending", {29'b0, pending_count}, 32'd0);
    check("rst_err", {31'b0, err_spurious}, 32'd0);
    check("rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Long load to x5, dependent issue on rs1=5
    set_issue(1, 5, 0, 0, 0, 0, 1);
    settle();
    check("ld5_stall", {31'b0, issue_stall}, 32'd0);
    step();
    set_issue(1, 6, 5, 1, 0, 0, 0);
    settle();
    check("dep_stall", {31'b0, issue_stall}, 32'd1);
    check("dep_pending", {29'b0, pending_count}, 32'd1);
    step(2);
    check("dep_stall_hold", {31'b0, issue_stall}, 32'd1);
    lsu_send(5, 32'hDEADBEEF);
    settle();
    check("dep_stall_buffered", {31'b0, issue_stall}, 32'd1);
    step();
    check("dep_stall_clear", {31'b0, issue_stall}, 32'd0);
    check("dep_we", {31'b0, rf_we}, 32'd1);
    check("dep_waddr", {27'b0, rf_waddr}, 32'd5);
    check("dep_wdata", rf_wdata, 32'hDEADBEEF);
    check("dep_fwd1", {31'b0, fwd1_valid}, 32'd1);
    check("dep_fwd2", {31'b0, fwd2_valid}, 32'd0);
    check("dep_pending0", {29'b0, pending_count}, 32'd0);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0);

    // MAX_PENDING limit
    for (int i = 1; i <= 4; i++) begin
      set_issue(1, 5'(i), 0, 0, 0, 0, 1);
      step();
    end
    set_issue(1, 8, 0, 0, 0, 0, 1);
    settle();
    check("max_pending", {29'b0, pending_count}, 32'd4);
    check("max_stall", {31'b0, issue_stall}, 32'd1);
    lsu_send(1, 32'h1111_0001);
    settle();
    check("max_stall_pop_cycle", {31'b0, issue_stall}, 32'd1);
    step();
    check("max_pending_dec", {29'b0, pending_count}, 32'd3);
    check("max_unstall", {31'b0, issue_stall}, 32'd0);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    check("max_refill", {29'b0, pending_count}, 32'd4);
    lsu_send(2, 32'h2222_0002);
    lsu_send(3, 32'h3333_0003);
    lsu_send(4, 32'h4444_0004);
    lsu_send(8, 32'h8888_0008);
    step(3);
    check("max_drain", {29'b0, pending_count}, 32'd0);

    // ALU stream to x3 racing two LSU returns
    set_issue(1, 10, 0, 0, 0, 0, 1);
    step();
    set_issue(1, 11, 0, 0, 0, 0, 1);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    alu_stalls = 0;
    fork
      for (int i = 0; i < 6; i++) alu_send(3, 32'hA000_0000 + i);
      begin
        lsu_send(10, 32'hB000_000A);
        lsu_send(11, 32'hB000_000B);
      end
    join
    step(4);
    check("race_alu_stalls", alu_stalls, 32'd1);
    check("race_pending", {29'b0, pending_count}, 32'd0);
    check("race_alu_q_empty", alu_q.size(), 32'd0);
    check("race_lsu_q_empty", lsu_q.size(), 32'd0);

    // Writes to x0
    alu_send(0, 32'h1);
    check("x0_alu_we", {31'b0, rf_we}, 32'd0);
    set_issue(1, 0, 0, 1, 0, 1, 1);
    settle();
    check("x0_stall", {31'b0, issue_stall}, 32'd0);
    step();
    set_issue(1, 9, 0, 1, 0, 1, 0);
    settle();
    check("x0_pending1", {29'b0, pending_count}, 32'd1);
    check("x0_rs0_nostall", {31'b0, issue_stall}, 32'd0);
    set_issue(0, 0, 0, 0, 0, 0, 0);
    lsu_send(0, 32'h5);
    step();
    check("x0_lsu_we", {31'b0, rf_we}, 32'd0);
    step();
    check("x0_pending0", {29'b0, pending_count}, 32'd0);
    check("x0_err", {31'b0, err_spurious}, 32'd0);

    // Spurious LSU return
    lsu_send(7, 32'h77);
    step();
    check("spur_err", {31'b0, err_spurious}, 32'd1);
    alu_send(9, 32'h99);
    step(2);
    check("spur_err_sticky", {31'b0, err_spurious}, 32'd1);

    // Reset mid-operation
    set_issue(1, 5, 0, 0, 0, 0, 1);
    step();
    set_issue(1, 12, 0, 0, 0, 0, 1);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    alu_valid = 1; alu_rd = 3; alu_data = 32'hC000_0000;
    lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hD000_0005;
    step();
    alu_data = 32'hC000_0001;
    lsu_rd = 12; lsu_data = 32'hD000_000C;
    step();
    alu_valid = 0; lsu_valid = 0;
    settle();
    check("mid_full", {31'b0, lsu_ready}, 32'd0);
    check("mid_pending", {29'b0, pending_count}, 32'd2);
    rst = 1'b1;
    set_issue(1, 13, 5, 1, 12, 1, 0);
    #1;
    check("mid_rst_we", {31'b0, rf_we}, 32'd0);
    check("mid_rst_pending", {29'b0, pending_count}, 32'd0);
    check("mid_rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    check("mid_rst_busy", {31'b0, issue_stall}, 32'd0);
    check("mid_rst_err", {31'b0, err_spurious}, 32'd0);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(3);
    check("post_rst_we", {31'b0, rf_we}, 32'd0);
    check("post_rst_alu_q", alu_q.size(), 32'd0);
    check("post_rst_lsu_q", lsu_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
Writeback and hazard controller that acts as the initiator of the register file's write port.
- Merges single-cycle ALU results and long-latency load (LSU) results into one registered write stream (rf_we/rf_waddr/rf_wdata).
- Tracks destinations of in-flight long ops in a busy scoreboard and stalls dependent issue.
- Forwards the write-stage value, because the regfile returns old data until the write edge.

Parameters:
XLEN, 32, data width
LSU_FIFO_DEPTH, 2, LSU result buffer entries (power of 2, >=2)
MAX_PENDING, 4, max outstanding long ops

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
issue_valid  input  1  decode presents an instruction
issue_rd  input  5  destination register
issue_rs1  input  5  source 1
issue_rs2  input  5  source 2
issue_use_rs1  input  1  rs1 is read
issue_use_rs2  input  1  rs2 is read
issue_is_long  input  1  result returns via LSU
issue_stall  output  1  hold decode (combinational)
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted
alu_rd  input  5  ALU destination
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU result valid
lsu_ready  output  1  LSU result accepted
lsu_rd  input  5  LSU destination
lsu_data  input  XLEN  LSU result
rf_we  output  1  regfile write enable (registered)
rf_waddr  output  5  regfile write address (registered)
rf_wdata  output  XLEN  regfile write data (registered)
fwd1_valid  output  1  forward rf_wdata for rs1
fwd2_valid  output  1  forward rf_wdata for rs2
pending_count  output  $clog2(MAX_PENDING+1)  outstanding long ops
err_spurious  output  1  sticky: LSU result for non-busy rd

Behaviour:
Reset (async, rst=1):
- busy[31:0]=0, FIFO empty, rf_we=0, rf_waddr=0, rf_wdata=0, pending_count=0, err_spurious=0.
- In-flight results are discarded; the LSU is reset by the same rst.

Issue fire = issue_valid & ~issue_stall. issue_stall=1 when issue_valid and any of:
- issue_use_rs1 & busy[issue_rs1]
- issue_use_rs2 & busy[issue_rs2]
- busy[issue_rd] (WAW)
- issue_is_long & pending_count==MAX_PENDING
- busy[0] is hard-wired 0.

Busy set/clear:
- On fire with issue_is_long & issue_rd!=0: busy[issue_rd]<=1 and pending_count++.
- issue_is_long with rd=0 still increments pending_count, but sets no busy bit.
- On FIFO pop: busy[head.rd]<=0 and pending_count--. Simultaneous fire and pop leaves pending_count unchanged.
- A same-cycle pop of rd does not unstall issue that cycle (stall uses the current busy state).

LSU path:
- lsu_ready = ~fifo_full. An LSU handshake pushes {lsu_rd, lsu_data}.
- Push with busy[lsu_rd]==0 and lsu_rd!=0 sets err_spurious (sticky until rst). The entry is still written.

Write-stage arbitration, evaluated every cycle:
1. FIFO full -> pop head; alu_ready=0.
2. Else alu_valid -> take ALU; alu_ready=1.
3. Else FIFO non-empty -> pop head.
4. Else rf_we<=0.

Write stage:
- Selected entry registered into rf_we/rf_waddr/rf_wdata, one cycle after acceptance.
- rd=0 gives rf_we<=0; busy and pending bookkeeping still apply.
- alu_ready=1 whenever the FIFO is not full, including when alu_valid=0.

Forwarding:
- fwd1_valid = rf_we & rf_waddr==issue_rs1 & issue_rs1!=0 (same rule for fwd2).
- Covers the cycle where busy is already clear but the regfile is not yet written.

Push and pop in the same cycle are both allowed; occupancy is unchanged when both occur on a full FIFO.

Decomposition:
- wb_pkg: XLEN, REG_AW=5, typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data}.
- One sub-module, wb_fifo: parameterized depth, wb_entry_t payload, push/pop/full/empty, pointer wrap using an extra MSB.

Test Plan:
1. Reset mid-operation: assert rst with 2 FIFO entries and busy[5]=1 -> next sample shows rf_we=0, pending_count=0, busy clear, lsu_ready=1.
2. Long load to x5, then dependent issue rs1=5:
   - issue_stall=1 until LSU returns {5, 0xDEADBEEF}.
   - Next cycle: rf_we=1, rf_waddr=5, fwd1_valid=1, stall=0.
3. ALU writes to x3 every cycle while LSU returns 2 results:
   - FIFO fills -> alu_ready=0 for one cycle; LSU entry written.
   - No ALU result lost (scoreboard compares the write sequence).
4. Issue 4 long ops (x1..x4), then a 5th -> stall on pending_count==4; one return -> 5th fires the next cycle.
5. Write to x0:
   - alu_rd=0, data 0x1 -> rf_we stays 0.
   - Long issue rd=0 -> pending_count 1 -> 0 on return, no stall on any rs=0.
6. LSU result for rd=7 with busy[7]=0 -> err_spurious=1 and it holds through later traffic until rst.
